// File: rtl/frame_collector_d.sv
// Byte-serial frame collector: after a one-cycle start strobe, captures FRAME_BYTES
// consecutive bytes into a wide frame and holds it until the consumer acknowledges.
module frame_collector_d #(
    parameter int FRAME_BYTES = 8
) (
    input  logic                     clkC,
    input  logic                     reset,
    input  logic                     readyC,
    input  logic [7:0]               sharedBusCD,
    input  logic                     frameAck,
    output logic                     acceptedD,
    output logic [8*FRAME_BYTES-1:0] frameD,
    output logic                     frameValidD,
    output logic                     busyD,
    output logic                     overrunD
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(FRAME_BYTES - 1);

    state_t     state;
    logic [3:0] cnt;
    // Low for the first edge after reset release so a strobe held through reset is not taken.
    logic       armed;

    always_ff @(posedge clkC or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            armed       <= 1'b0;
            acceptedD   <= 1'b0;
            frameD      <= '0;
            frameValidD <= 1'b0;
            busyD       <= 1'b0;
            overrunD    <= 1'b0;
        end else begin
            armed     <= 1'b1;
            acceptedD <= 1'b0;
            overrunD  <= 1'b0;
            case (state)
                IDLE: begin
                    if (readyC && armed) begin
                        state     <= COLLECT;
                        cnt       <= '0;
                        acceptedD <= 1'b1;
                        busyD     <= 1'b1;
                    end
                end
                COLLECT: begin
                    for (int unsigned i = 0; i < FRAME_BYTES; i++) begin
                        if (cnt == 4'(i)) begin
                            frameD[8*i +: 8] <= sharedBusCD;
                        end
                    end
                    if (readyC) begin
                        overrunD <= 1'b1;
                    end
                    if (cnt >= LAST_CNT) begin
                        state       <= HOLD;
                        cnt         <= '0;
                        frameValidD <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                HOLD: begin
                    if (frameAck) begin
                        frameValidD <= 1'b0;
                        cnt         <= '0;
                        if (readyC) begin
                            state     <= COLLECT;
                            acceptedD <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busyD <= 1'b0;
                        end
                    end else if (readyC) begin
                        overrunD <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    cnt         <= '0;
                    frameValidD <= 1'b0;
                    busyD       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_collector_d.sv
// Directed bench for frame_collector_d: 8-byte and 2-byte instances with hand-computed frames.
module tb_frame_collector_d;

    logic        clkC;
    logic        reset;
    logic        readyC, frameAck;
    logic [7:0]  sharedBusCD;
    logic        acceptedD, frameValidD, busyD, overrunD;
    logic [63:0] frameD;

    logic        readyC2, frameAck2;
    logic [7:0]  sharedBusCD2;
    logic        acceptedD2, frameValidD2, busyD2, overrunD2;
    logic [15:0] frameD2;

    int checks = 0;
    int errors = 0;

    frame_collector_d #(.FRAME_BYTES(8)) dut8 (
        .clkC(clkC), .reset(reset), .readyC(readyC), .sharedBusCD(sharedBusCD),
        .frameAck(frameAck), .acceptedD(acceptedD), .frameD(frameD),
        .frameValidD(frameValidD), .busyD(busyD), .overrunD(overrunD)
    );

    frame_collector_d #(.FRAME_BYTES(2)) dut2 (
        .clkC(clkC), .reset(reset), .readyC(readyC2), .sharedBusCD(sharedBusCD2),
        .frameAck(frameAck2), .acceptedD(acceptedD2), .frameD(frameD2),
        .frameValidD(frameValidD2), .busyD(busyD2), .overrunD(overrunD2)
    );

    initial begin
        clkC = 1'b0;
        forever #5 clkC = ~clkC;
    end

    task automatic tick();
        @(posedge clkC);
        #1;
    endtask

    task automatic load_frame(input logic [63:0] data);
        readyC = 1'b1;
        tick();
        readyC = 1'b0;
        for (int k = 0; k < 8; k++) begin
            sharedBusCD = data[8*k +: 8];
            tick();
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({acceptedD, frameValidD, busyD, overrunD, frameD} !== 68'd0) begin
            errors++;
            $display("FAIL reset8 got acc=%b val=%b busy=%b ovr=%b frame=%h expected all 0",
                     acceptedD, frameValidD, busyD, overrunD, frameD);
        end
        checks++;
        if ({acceptedD2, frameValidD2, busyD2, overrunD2, frameD2} !== 20'd0) begin
            errors++;
            $display("FAIL reset2 got acc=%b val=%b busy=%b ovr=%b frame=%h expected all 0",
                     acceptedD2, frameValidD2, busyD2, overrunD2, frameD2);
        end
        readyC = 1'b1;
        @(negedge clkC);
        reset = 1'b1;
        tick();
        readyC = 1'b0;
        checks++;
        if (acceptedD !== 1'b0 || busyD !== 1'b0) begin
            errors++;
            $display("FAIL release_no_start got acc=%b busy=%b expected 0 0", acceptedD, busyD);
        end
    endtask

    task automatic test_single_frame();
        logic [63:0] exp = 64'h8877665544332211;
        readyC = 1'b1;
        tick();
        readyC = 1'b0;
        checks++;
        if (acceptedD !== 1'b1 || busyD !== 1'b1) begin
            errors++;
            $display("FAIL single_accept got acc=%b busy=%b expected 1 1", acceptedD, busyD);
        end
        for (int k = 0; k < 8; k++) begin
            sharedBusCD = 8'(8'h11 * (k + 1));
            tick();
            if (k == 0) begin
                checks++;
                if (acceptedD !== 1'b0) begin
                    errors++;
                    $display("FAIL single_accept_pulse got %b expected 0", acceptedD);
                end
            end
            checks++;
            if (frameValidD !== (k == 7)) begin
                errors++;
                $display("FAIL single_valid_edge%0d got %b expected %b", k + 2, frameValidD, (k == 7));
            end
        end
        checks++;
        if (frameD !== exp) begin
            errors++;
            $display("FAIL single_frame got %h expected %h", frameD, exp);
        end
        sharedBusCD = 8'hEE;
        tick();
        tick();
        checks++;
        if (frameValidD !== 1'b1 || frameD !== exp || busyD !== 1'b1) begin
            errors++;
            $display("FAIL single_hold got val=%b busy=%b frame=%h expected 1 1 %h",
                     frameValidD, busyD, frameD, exp);
        end
        frameAck = 1'b1;
        tick();
        frameAck = 1'b0;
        checks++;
        if (frameValidD !== 1'b0 || busyD !== 1'b0) begin
            errors++;
            $display("FAIL single_ack got val=%b busy=%b expected 0 0", frameValidD, busyD);
        end
        frameAck = 1'b1;
        tick();
        frameAck = 1'b0;
        checks++;
        if (busyD !== 1'b0 || acceptedD !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack_ignored got busy=%b acc=%b expected 0 0", busyD, acceptedD);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp = 64'hA8A7A6A5A4A3A2A1;
        int ovr = 0;
        load_frame(64'h1122334455667788);
        frameAck = 1'b1;
        readyC = 1'b1;
        tick();
        frameAck = 1'b0;
        readyC = 1'b0;
        checks++;
        if (acceptedD !== 1'b1 || overrunD !== 1'b0 || frameValidD !== 1'b0 || busyD !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart got acc=%b ovr=%b val=%b busy=%b expected 1 0 0 1",
                     acceptedD, overrunD, frameValidD, busyD);
        end
        for (int k = 0; k < 8; k++) begin
            sharedBusCD = 8'hA1 + 8'(k);
            frameAck = (k == 2);
            tick();
            if (overrunD) ovr++;
        end
        frameAck = 1'b0;
        checks++;
        if (ovr !== 0) begin
            errors++;
            $display("FAIL b2b_overrun got %0d pulses expected 0", ovr);
        end
        checks++;
        if (frameD !== exp || frameValidD !== 1'b1) begin
            errors++;
            $display("FAIL b2b_frame got %h val=%b expected %h 1", frameD, frameValidD, exp);
        end
        frameAck = 1'b1;
        tick();
        frameAck = 1'b0;
    endtask

    task automatic test_overrun();
        logic [63:0] exp = 64'h8877665544332211;
        int ovr = 0;
        readyC = 1'b1;
        tick();
        readyC = 1'b0;
        for (int k = 0; k < 8; k++) begin
            sharedBusCD = 8'(8'h11 * (k + 1));
            readyC = (k == 3);
            tick();
            if (overrunD) ovr++;
            if (k == 3) begin
                checks++;
                if (overrunD !== 1'b1 || acceptedD !== 1'b0) begin
                    errors++;
                    $display("FAIL ovr_collect got ovr=%b acc=%b expected 1 0", overrunD, acceptedD);
                end
            end
        end
        readyC = 1'b1;
        tick();
        readyC = 1'b0;
        if (overrunD) ovr++;
        checks++;
        if (frameValidD !== 1'b1 || busyD !== 1'b1 || acceptedD !== 1'b0) begin
            errors++;
            $display("FAIL ovr_hold_state got val=%b busy=%b acc=%b expected 1 1 0",
                     frameValidD, busyD, acceptedD);
        end
        tick();
        if (overrunD) ovr++;
        checks++;
        if (ovr !== 2) begin
            errors++;
            $display("FAIL ovr_count got %0d expected 2", ovr);
        end
        checks++;
        if (frameD !== exp) begin
            errors++;
            $display("FAIL ovr_frame got %h expected %h", frameD, exp);
        end
        frameAck = 1'b1;
        tick();
        frameAck = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        logic [63:0] exp = 64'h0807060504030201;
        readyC = 1'b1;
        tick();
        readyC = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sharedBusCD = 8'hC0 + 8'(k);
            tick();
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({acceptedD, frameValidD, busyD, overrunD, frameD} !== 68'd0) begin
            errors++;
            $display("FAIL midreset got acc=%b val=%b busy=%b ovr=%b frame=%h expected all 0",
                     acceptedD, frameValidD, busyD, overrunD, frameD);
        end
        @(negedge clkC);
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (busyD !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle got busy=%b expected 0", busyD);
        end
        load_frame(exp);
        checks++;
        if (frameD !== exp || frameValidD !== 1'b1) begin
            errors++;
            $display("FAIL midreset_frame got %h val=%b expected %h 1", frameD, frameValidD, exp);
        end
        frameAck = 1'b1;
        tick();
        frameAck = 1'b0;
    endtask

    task automatic test_two_byte();
        readyC2 = 1'b1;
        tick();
        readyC2 = 1'b0;
        checks++;
        if (acceptedD2 !== 1'b1 || busyD2 !== 1'b1) begin
            errors++;
            $display("FAIL fb2_accept got acc=%b busy=%b expected 1 1", acceptedD2, busyD2);
        end
        sharedBusCD2 = 8'h5A;
        tick();
        checks++;
        if (frameValidD2 !== 1'b0) begin
            errors++;
            $display("FAIL fb2_valid_edge2 got %b expected 0", frameValidD2);
        end
        sharedBusCD2 = 8'hC3;
        tick();
        checks++;
        if (frameValidD2 !== 1'b1 || frameD2 !== 16'hC35A) begin
            errors++;
            $display("FAIL fb2_frame got %h val=%b expected c35a 1", frameD2, frameValidD2);
        end
        frameAck2 = 1'b1;
        tick();
        frameAck2 = 1'b0;
        checks++;
        if (frameValidD2 !== 1'b0 || busyD2 !== 1'b0 || frameD2 !== 16'hC35A) begin
            errors++;
            $display("FAIL fb2_ack got val=%b busy=%b frame=%h expected 0 0 c35a",
                     frameValidD2, busyD2, frameD2);
        end
    endtask

    initial begin
        reset = 1'b0;
        readyC = 1'b0;
        frameAck = 1'b0;
        sharedBusCD = 8'h00;
        readyC2 = 1'b0;
        frameAck2 = 1'b0;
        sharedBusCD2 = 8'h00;
        test_reset();
        tick();
        test_single_frame();
        test_back_to_back();
        test_overrun();
        test_reset_mid_burst();
        test_two_byte();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_collector_d.md
FRAME_COLLECTOR_D -- requirements
Module: frame_collector_d

Interface
REQ-001 Parameter FRAME_BYTES, default 8: bytes per frame; legal range 2..8.
REQ-002 clkC  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 readyC  input  1  upstream start strobe; high for one cycle before a burst.
REQ-005 sharedBusCD  input  8  upstream byte bus; one new byte per cycle during a burst.
REQ-006 frameAck  input  1  downstream consumer acknowledge of frameD.
REQ-007 acceptedD  output  1  registered one-cycle pulse acknowledging the upstream start.
REQ-008 frameD  output  8*FRAME_BYTES  assembled frame; byte 0 in [7:0], byte k in [8k+7:8k].
REQ-009 frameValidD  output  1  frameD holds a complete frame awaiting frameAck.
REQ-010 busyD  output  1  high in COLLECT and HOLD states.
REQ-011 overrunD  output  1  registered one-cycle pulse: start strobe dropped.

Function
REQ-012 The block SHALL implement states IDLE, COLLECT and HOLD with a byte counter cnt of 4 bits.
REQ-013 Start edge: the rising edge at which readyC=1 and the start is accepted (see REQ-014, REQ-019).
REQ-014 In IDLE, readyC=1 at an edge SHALL move to COLLECT with cnt=0 and set acceptedD=1 for exactly the following cycle.
REQ-015 Byte k (k=0..FRAME_BYTES-1) SHALL be sampled from sharedBusCD at the (k+1)th rising edge after the start edge and written to frameD lane k.
REQ-016 After byte FRAME_BYTES-1 is written, the block SHALL enter HOLD with frameValidD=1 from the following cycle; latency from start edge to frameValidD = FRAME_BYTES+1 edges.
REQ-017 In COLLECT, readyC is ignored for data; readyC=1 SHALL pulse overrunD for one cycle; the burst in progress SHALL continue unchanged.
REQ-018 In HOLD, frameD SHALL stay stable; frameAck=1 with readyC=0 SHALL return to IDLE and clear frameValidD next cycle.
REQ-019 In HOLD, frameAck=1 and readyC=1 at the same edge SHALL clear frameValidD, pulse acceptedD, and enter COLLECT with cnt=0 (back-to-back frame, no overrun).
REQ-020 In HOLD, readyC=1 with frameAck=0 SHALL pulse overrunD and leave state and frameD unchanged.
REQ-021 frameAck outside HOLD SHALL be ignored.
REQ-022 Lanes above the written bytes are not cleared between frames; each frame overwrites all FRAME_BYTES lanes.
REQ-023 cnt SHALL never exceed FRAME_BYTES-1; illegal state encodings SHALL return to IDLE next edge.
REQ-024 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-025 reset=0 SHALL immediately force IDLE, cnt=0, acceptedD=0, frameValidD=0, busyD=0, overrunD=0, frameD=0.
REQ-026 Reset asserted mid-COLLECT or in HOLD SHALL discard the partial or pending frame; after release, the block waits for a fresh readyC.
REQ-027 Release of reset SHALL take effect at the first rising clkC after deassertion; no start is accepted on that edge if readyC was sampled during reset.

Verification
REQ-028 Single frame, FRAME_BYTES=8: readyC pulse, then bytes 11,22,...,88 hex on consecutive cycles -> acceptedD one cycle, frameD=0x8877665544332211, frameValidD at edge 9, held until frameAck.
REQ-029 Back-to-back: in HOLD, drive frameAck=1 and readyC=1 together, then bytes A1..A8 -> no overrunD, frameD=0xA8A7A6A5A4A3A2A1 nine edges later.
REQ-030 Overrun: readyC=1 at byte 3 of a burst and again in HOLD without ack -> overrunD pulses twice, frameD equals the original burst.
REQ-031 Reset mid-burst after 4 bytes -> all outputs 0 immediately; next full burst 01..08 yields frameD=0x0807060504030201.
REQ-032 FRAME_BYTES=2: bytes 5A,C3 -> frameD=0xC35A, frameValidD at edge 3 after start.
